apb_controller_fsm: RTL and testbench

//  Downstream stage of the AHB slave interface in the AHB-to-APB bridge. Accepts one
//  AHB transfer at a time (qualified by VALID), holds the AHB data phase with HREADYOUT,

---
 rtl/apb_controller_fsm.sv | 165 ++++++++++++++++
 tb/tb_apb_controller_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_controller_fsm.sv
// rtl/apb_controller_fsm.sv - AHB-to-APB bridge controller: one transfer at a time, APB SETUP/ACCESS, wait states, error response
module apb_controller_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VALID,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic [3:0]        HSEL,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [3:0]        PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // next-cycle values of the control outputs, registered below so every output is a flop
  logic [3:0]       psel_d;
  logic             penable_d;
  logic             hreadyout_d;
  logic [1:0]       hresp_d;

  // last stalled ACCESS cycle allowed before the transfer is aborted
  assign timeout_hit = (state == ST_ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // state register; reset abandons any transfer in flight without a response
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode; VALID is only looked at in IDLE so one transfer is outstanding at most
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (VALID) next_state = ST_CAPT;
      ST_CAPT:   next_state = (HSEL == 4'b0000) ? ST_ERR1 : ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          next_state = PSLVERR ? ST_ERR1 : ST_IDLE;
        end else if (timeout_hit) begin
          next_state = ST_ERR1;
        end
      end
      ST_ERR1:   next_state = ST_ERR2;
      ST_ERR2:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // control outputs as a function of the state being entered
  always_comb begin
    psel_d      = 4'b0000;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    case (next_state)
      ST_IDLE: begin
        hreadyout_d = 1'b1;
      end
      ST_CAPT: begin
        hreadyout_d = 1'b0;
      end
      ST_SETUP: begin
        // SETUP is only entered from CAPT, where HSEL is the registered select for this transfer
        psel_d      = HSEL;
        hreadyout_d = 1'b0;
      end
      ST_ACCESS: begin
        psel_d      = PSEL;
        penable_d   = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = RESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = RESP_ERROR;
      end
      default: begin
        hreadyout_d = 1'b1;
      end
    endcase
  end

  // control output registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PSEL      <= 4'b0000;
      PENABLE   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
    end else begin
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
    end
  end

  // address/data capture, read data return and the ACCESS stall counter
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      HRDATA   <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == ST_IDLE && VALID) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      // write data arrives in the AHB data phase, one cycle behind the address
      if (state == ST_CAPT && PWRITE) begin
        PWDATA <= HWDATA;
      end
      if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
      if (state == ST_ACCESS && next_state == ST_ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_controller_fsm.sv
// tb/tb_apb_controller_fsm.sv - directed vector bench for apb_controller_fsm
module tb_apb_controller_fsm;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        VALID;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [3:0]  HSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  hsel;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  e_psel;
    logic        e_penable;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_hreadyout;
    logic [1:0]  e_hresp;
    logic [31:0] e_hrdata;
  } vec_t;

  vec_t vecs[$];

  apb_controller_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .VALID     (VALID),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HSEL      (HSEL),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] s, input logic [31:0] rd, input logic rdy, input logic err,
                     input logic [3:0] e_psel, input logic e_pen, input logic e_pw,
                     input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                     input logic e_hrdy, input logic [1:0] e_hresp, input logic [31:0] e_hrdata);
    vec_t r;
    r.valid = v;  r.haddr = a;  r.hwrite = w;  r.hwdata = wd;
    r.hsel = s;   r.prdata = rd; r.pready = rdy; r.pslverr = err;
    r.e_psel = e_psel; r.e_penable = e_pen; r.e_pwrite = e_pw;
    r.e_paddr = e_paddr; r.e_pwdata = e_pwdata; r.e_hreadyout = e_hrdy;
    r.e_hresp = e_hresp; r.e_hrdata = e_hrdata;
    vecs.push_back(r);
  endtask

  // drive inputs on the falling edge, then sample just after the rising edge
  task automatic drive_cycle(input logic v, input logic [31:0] a, input logic w, input logic [31:0] wd,
                             input logic [3:0] s, input logic [31:0] rd, input logic rdy, input logic err);
    @(negedge HCLK);
    VALID = v; HADDR = a; HWRITE = w; HWDATA = wd;
    HSEL = s; PRDATA = rd; PREADY = rdy; PSLVERR = err;
    @(posedge HCLK);
    #1;
  endtask

  int acc_cycles;
  int psel_bad;

  initial begin
    HRESET = 1'b1; VALID = 1'b0; HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
    HSEL = 4'b0000; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // write, no wait states
    add(1, 32'h10,       1, 32'h0,        4'b0001, 32'h0, 0, 0,  4'b0000, 0, 1, 32'h10, 32'h0,        0, 2'b00, 32'h0);
    add(0, 32'h10,       1, 32'hA5A51234, 4'b0001, 32'h0, 0, 0,  4'b0001, 0, 1, 32'h10, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h10,       1, 32'hA5A51234, 4'b0001, 32'h0, 1, 0,  4'b0001, 1, 1, 32'h10, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h10,       1, 32'hA5A51234, 4'b0001, 32'h0, 1, 0,  4'b0000, 0, 1, 32'h10, 32'hA5A51234, 1, 2'b00, 32'h0);
    // read, two PREADY=0 cycles, VALID in ACCESS ignored, read does not capture HWDATA
    add(1, 32'h00020000, 0, 32'h0,        4'b0010, 32'h0, 0, 0,  4'b0000, 0, 0, 32'h00020000, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h00020000, 0, 32'h99999999, 4'b0010, 32'h0, 0, 0,  4'b0010, 0, 0, 32'h00020000, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h00020000, 0, 32'h0,        4'b0010, 32'h0, 0, 0,  4'b0010, 1, 0, 32'h00020000, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(1, 32'hFFFF0000, 1, 32'h0,        4'b0010, 32'h0, 0, 0,  4'b0010, 1, 0, 32'h00020000, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h00020000, 0, 32'h0,        4'b0010, 32'h0, 0, 0,  4'b0010, 1, 0, 32'h00020000, 32'hA5A51234, 0, 2'b00, 32'h0);
    add(0, 32'h00020000, 0, 32'h0,        4'b0010, 32'hDEADBEEF, 1, 0, 4'b0000, 0, 0, 32'h00020000, 32'hA5A51234, 1, 2'b00, 32'hDEADBEEF);
    // back-to-back write ending in PSLVERR, VALID ignored during the error response
    add(1, 32'h30,       1, 32'h0,        4'b0100, 32'h0, 0, 0,  4'b0000, 0, 1, 32'h30, 32'hA5A51234, 0, 2'b00, 32'hDEADBEEF);
    add(0, 32'h30,       1, 32'h11112222, 4'b0100, 32'h0, 0, 0,  4'b0100, 0, 1, 32'h30, 32'h11112222, 0, 2'b00, 32'hDEADBEEF);
    add(0, 32'h30,       1, 32'h11112222, 4'b0100, 32'h0, 1, 1,  4'b0100, 1, 1, 32'h30, 32'h11112222, 0, 2'b00, 32'hDEADBEEF);
    add(1, 32'h30,       1, 32'h11112222, 4'b0100, 32'h12345678, 1, 1, 4'b0000, 0, 1, 32'h30, 32'h11112222, 0, 2'b01, 32'hDEADBEEF);
    add(1, 32'h30,       1, 32'h11112222, 4'b0100, 32'h0, 0, 0,  4'b0000, 0, 1, 32'h30, 32'h11112222, 1, 2'b01, 32'hDEADBEEF);
    add(0, 32'h30,       1, 32'h11112222, 4'b0100, 32'h0, 0, 0,  4'b0000, 0, 1, 32'h30, 32'h11112222, 1, 2'b00, 32'hDEADBEEF);
    // unmapped select: no APB transfer, two-cycle ERROR
    add(1, 32'h40,       0, 32'h0,        4'b0000, 32'h0, 0, 0,  4'b0000, 0, 0, 32'h40, 32'h11112222, 0, 2'b00, 32'hDEADBEEF);
    add(0, 32'h40,       0, 32'h0,        4'b0000, 32'h0, 0, 0,  4'b0000, 0, 0, 32'h40, 32'h11112222, 0, 2'b01, 32'hDEADBEEF);
    add(0, 32'h40,       0, 32'h0,        4'b0000, 32'h0, 0, 0,  4'b0000, 0, 0, 32'h40, 32'h11112222, 1, 2'b01, 32'hDEADBEEF);
    add(0, 32'h40,       0, 32'h0,        4'b0000, 32'h0, 0, 0,  4'b0000, 0, 0, 32'h40, 32'h11112222, 1, 2'b00, 32'hDEADBEEF);

    // reset state
    repeat (2) @(posedge HCLK);
    #1;
    check("reset.psel",      32'(PSEL),      32'h0);
    check("reset.penable",   32'(PENABLE),   32'h0);
    check("reset.pwrite",    32'(PWRITE),    32'h0);
    check("reset.paddr",     PADDR,          32'h0);
    check("reset.pwdata",    PWDATA,         32'h0);
    check("reset.hreadyout", 32'(HREADYOUT), 32'h1);
    check("reset.hresp",     32'(HRESP),     32'h0);
    check("reset.hrdata",    HRDATA,         32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].valid, vecs[i].haddr, vecs[i].hwrite, vecs[i].hwdata,
                  vecs[i].hsel, vecs[i].prdata, vecs[i].pready, vecs[i].pslverr);
      check($sformatf("row%0d.psel", i),      32'(PSEL),      32'(vecs[i].e_psel));
      check($sformatf("row%0d.penable", i),   32'(PENABLE),   32'(vecs[i].e_penable));
      check($sformatf("row%0d.pwrite", i),    32'(PWRITE),    32'(vecs[i].e_pwrite));
      check($sformatf("row%0d.paddr", i),     PADDR,          vecs[i].e_paddr);
      check($sformatf("row%0d.pwdata", i),    PWDATA,         vecs[i].e_pwdata);
      check($sformatf("row%0d.hreadyout", i), 32'(HREADYOUT), 32'(vecs[i].e_hreadyout));
      check($sformatf("row%0d.hresp", i),     32'(HRESP),     32'(vecs[i].e_hresp));
      check($sformatf("row%0d.hrdata", i),    HRDATA,         vecs[i].e_hrdata);
    end

    // timeout: PREADY never rises, abort after 16 ACCESS cycles
    drive_cycle(1, 32'h50, 1, 32'h0, 4'b1000, 32'h0, 0, 0);
    drive_cycle(0, 32'h50, 1, 32'h5, 4'b1000, 32'h0, 0, 0);
    check("tmo.setup_psel",    32'(PSEL),    32'h8);
    check("tmo.setup_penable", 32'(PENABLE), 32'h0);
    acc_cycles = 0;
    psel_bad   = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(0, 32'h50, 1, 32'h5, 4'b1000, 32'h0, 0, 0);
      if (!PENABLE) break;
      acc_cycles++;
      if (PSEL !== 4'b1000) psel_bad++;
    end
    check("tmo.access_cycles", 32'(acc_cycles), 32'd16);
    check("tmo.psel_held",     32'(psel_bad),   32'd0);
    check("tmo.err1_psel",     32'(PSEL),       32'h0);
    check("tmo.err1_hresp",    32'(HRESP),      32'h1);
    check("tmo.err1_hready",   32'(HREADYOUT),  32'h0);
    drive_cycle(0, 32'h50, 1, 32'h5, 4'b1000, 32'h0, 0, 0);
    check("tmo.err2_hresp",    32'(HRESP),      32'h1);
    check("tmo.err2_hready",   32'(HREADYOUT),  32'h1);
    drive_cycle(0, 32'h50, 1, 32'h5, 4'b1000, 32'h0, 0, 0);
    check("tmo.idle_hresp",    32'(HRESP),      32'h0);
    check("tmo.idle_pwdata",   PWDATA,          32'h5);

    // reset held two cycles in the middle of ACCESS
    drive_cycle(1, 32'h60, 0, 32'h0, 4'b0001, 32'h0, 0, 0);
    drive_cycle(0, 32'h60, 0, 32'h0, 4'b0001, 32'h0, 0, 0);
    drive_cycle(0, 32'h60, 0, 32'h0, 4'b0001, 32'h0, 0, 0);
    check("rst.access_penable", 32'(PENABLE), 32'h1);
    HRESET = 1'b1;
    drive_cycle(0, 32'h60, 0, 32'h0, 4'b0001, 32'hCAFEF00D, 1, 0);
    check("rst.e1_psel",    32'(PSEL),      32'h0);
    check("rst.e1_penable", 32'(PENABLE),   32'h0);
    check("rst.e1_hready",  32'(HREADYOUT), 32'h1);
    check("rst.e1_hresp",   32'(HRESP),     32'h0);
    drive_cycle(0, 32'h60, 0, 32'h0, 4'b0001, 32'hCAFEF00D, 1, 0);
    check("rst.e2_hrdata",  HRDATA,         32'h0);
    check("rst.e2_paddr",   PADDR,          32'h0);
    HRESET = 1'b0;
    drive_cycle(0, 32'h60, 0, 32'h0, 4'b0001, 32'hCAFEF00D, 1, 0);
    check("rst.after_psel",   32'(PSEL),      32'h0);
    check("rst.after_hready", 32'(HREADYOUT), 32'h1);
    check("rst.after_hresp",  32'(HRESP),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
